// File: rtl/pin_sampler_pkg.sv
// Shared constants for the pin sampling path: mode codes, FSM state encoding
// and timestamp width.
`ifndef IO_PINS
`define IO_PINS 16
`endif

package pin_sampler_pkg;

  localparam logic MODE_POLL   = 1'b0;
  localparam logic MODE_CHANGE = 1'b1;

  typedef enum logic {
    ST_ARM = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  localparam int TS_WIDTH = 32;

endpackage

// File: rtl/pin_compress.sv
// Combinational pin compaction: the data bits selected by mask are packed
// towards the LSB in mask order; bits above popcount(mask) read as 0.
module pin_compress #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] result
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDXW-1:0] idx_s;

  // Walk the mask from the LSB, placing each selected bit at the next free slot
  always_comb begin
    result = '0;
    idx_s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        result[idx_s] = data[i];
        idx_s         = idx_s + 1'b1;
      end else begin
        idx_s = idx_s;
      end
    end
  end

endmodule

// File: rtl/pin_sampler.sv
// Synchronises IO pins, compacts the masked ones and hands words to the core
// over valid/ready. Define PIN_SAMPLER_TIMESTAMP_EN to add the out_time port.
`ifndef IO_PINS
`define IO_PINS 16
`endif

module pin_sampler
  import pin_sampler_pkg::*;
#(
  parameter int WIDTH       = `IO_PINS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] mask_wdata,
  input  logic             mask_we,
  input  logic             mode,
  input  logic             sample_req,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] mask
`ifdef PIN_SAMPLER_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0] out_time
`endif
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] s_s;
  logic [WIDTH-1:0] c_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             ovf_r;
  state_e           state_r;
  state_e           state_nxt_s;
  logic             raw_event_s;
  logic             load_s;
  logic             drop_s;

  // Pin synchroniser chain into the core clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= io_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  pin_compress #(
    .WIDTH (WIDTH)
  ) u_compress (
    .data   (s_s),
    .mask   (mask_r),
    .result (c_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ARM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and event generation; a mask write re-arms and swallows events
  always_comb begin
    state_nxt_s = state_r;
    raw_event_s = 1'b0;
    if (mask_we) begin
      state_nxt_s = ST_ARM;
    end else begin
      case (state_r)
        ST_ARM: begin
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          state_nxt_s = ST_RUN;
          if (mode == MODE_CHANGE) begin
            raw_event_s = (c_s != prev_r);
          end else begin
            raw_event_s = sample_req;
          end
        end
        default: begin
          state_nxt_s = ST_ARM;
        end
      endcase
    end
  end

  assign load_s = raw_event_s && (!valid_r || out_ready);
  assign drop_s = raw_event_s && valid_r && !out_ready;

  // Change-detect reference: reloaded while arming and on every event
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= '0;
    end else if ((state_r == ST_ARM) || raw_event_s) begin
      prev_r <= c_s;
    end else begin
      prev_r <= prev_r;
    end
  end

  // Mask register, one-entry output buffer and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r  <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (mask_we) begin
        mask_r  <= mask_wdata;
        valid_r <= 1'b0;
      end else if (load_s) begin
        data_r  <= c_s;
        valid_r <= 1'b1;
      end else if (valid_r && out_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      // a drop in the same cycle as a clear keeps the flag set
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign overflow  = ovf_r;
  assign mask      = mask_r;

`ifdef PIN_SAMPLER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_r;
  logic [TS_WIDTH-1:0] ts_out_r;

  // Free-running timestamp, captured whenever a word loads
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_r <= '0;
      ts_out_r <= '0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 32'd1;
      if (load_s && !mask_we) begin
        ts_out_r <= ts_cnt_r;
      end else begin
        ts_out_r <= ts_out_r;
      end
    end
  end

  assign out_time = ts_out_r;
`endif

endmodule

// File: doc/pin_sampler.md
Name: pin_sampler

Overview:
- Registered input-side stage that feeds `pin_compress`.
- Synchronises raw IO pins into the core clock domain and holds the per-core pin mask register.
- Compacts masked pins to the LSBs through a `pin_compress` instance.
- Delivers compacted words to the owning processor core over a valid/ready handshake, either on request (poll) or whenever the compacted value changes (on-change).

Parameters:
- WIDTH, default `IO_PINS: pin count; width of data, mask and result.
- SYNC_STAGES, default 2: synchroniser depth, legal 1..4.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- io_in  in  WIDTH  raw asynchronous pin levels.
- mask_wdata  in  WIDTH  new mask value.
- mask_we  in  1  load mask_wdata into the mask register.
- mode  in  1  0 = poll, 1 = on-change.
- sample_req  in  1  poll-mode capture request, single-cycle pulse.
- out_data  out  WIDTH  compacted word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word this cycle.
- overflow  out  1  sticky: at least one word was dropped.
- ovf_clr  in  1  clear overflow.
- mask  out  WIDTH  current mask register.

Behaviour:
- Reset values: sync chain = 0, mask = 0, prev = 0, out_data = 0, out_valid = 0, overflow = 0, state = ARM.
- Synchroniser: SYNC_STAGES flops per bit. s = last stage.
- Compaction: c = pin_compress(s, mask), combinational. Bit i of c is the i-th set mask bit counting from the LSB, taking the corresponding s bit. Bits above popcount(mask) are 0.
- FSM, two states:
  - ARM: prev <= c; no event generated; next state RUN. Entered after reset and in the cycle after any mask_we.
  - RUN: raw event = (mode == 0) ? sample_req : (c != prev). On a raw event, prev <= c. Any mask_we returns the FSM to ARM.
- mask_we:
  - mask <= mask_wdata.
  - out_valid <= 0 (pending word discarded, overflow unaffected).
  - Any raw event in the same cycle is suppressed.
- Output buffer, one entry. On a raw event:
  - Load when free: if !out_valid, or out_valid && out_ready, then out_data <= c and out_valid <= 1. Accept and reload in the same cycle gives back-to-back words.
  - Drop when full: if out_valid && !out_ready, keep the old word, drop c and set overflow <= 1.
- Handshake:
  - No event and out_valid && out_ready: out_valid <= 0.
  - out_data stays stable while out_valid && !out_ready.
- overflow:
  - ovf_clr clears it.
  - A set condition in the same cycle as ovf_clr wins: overflow stays 1.
- Latency, on-change mode: pin edge to out_valid high = SYNC_STAGES + 1 clocks (3 with default).
- Latency, poll mode: sample_req to out_valid = 1 clock. The sampled value is s at the request cycle.
- Mask all zero: c = 0, so on-change never fires; poll returns 0.
- Mode changes take effect immediately. prev is not reloaded.
- rst has priority over all other inputs in the same cycle.

Optional Feature:
- Macro: PIN_SAMPLER_TIMESTAMP_EN.
- When defined:
  - Adds output out_time [31:0].
  - A 32-bit free-running counter, reset 0, increments every clock and wraps 0xFFFFFFFF -> 0.
  - Its value is captured into out_time whenever out_data loads. out_time is 0 on reset.
- When undefined: no port and no counter. Behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - MODE_POLL = 1'b0, MODE_CHANGE = 1'b1.
  - State encoding ST_ARM = 1'b0, ST_RUN = 1'b1.
  - TS_WIDTH = 32.
- Sub-module: one instance of the existing `pin_compress` for the combinational compaction. Synchroniser, FSM and buffer stay in pin_sampler.

Test Plan (WIDTH = 16, SYNC_STAGES = 2):
- Poll compaction: mask_we with 0x4945, io_in = 0x9D35, wait 3 clocks, pulse sample_req with out_ready = 1 -> next cycle out_valid = 1, out_data = 0x001B.
- On-change latency: mode = 1, mask = 0x00FF, io_in 0x0000 -> 0x0005 at edge N -> out_valid rises after edge N+3 with out_data = 0x0005. A change on unmasked bit 0x0100 produces no event.
- Overflow: out_ready = 0, two on-change events 0x0001 then 0x0003 -> out_data stays 0x0001, overflow = 1. Then ovf_clr -> overflow = 0. out_ready = 1 -> out_valid = 0.
- Back-to-back: out_ready held 1, poll pulses on consecutive cycles with io_in changing 0x0001, 0x0002 (mask 0xFFFF) -> out_valid stays 1, out_data updates each cycle, overflow = 0.
- Mask write mid-operation: out_valid = 1 pending and mask_we in the same cycle as an on-change event -> out_valid = 0, no new word. The following ARM cycle produces no event even though c changed.
- Reset mid-operation: assert rst with out_valid = 1, overflow = 1 -> all outputs 0 next cycle. With the timestamp macro defined, out_time = 0 and the counter restarts at 0.
